// File: rtl/cmd_link_rx_pkg.sv
// Shared constants, state types and command sanitising for the handset link receiver.
package cmd_link_pkg;

  // Packet header byte; the checksum byte is HDR ^ CMD.
  localparam logic [7:0] HDR = 8'hA5;

  // Bit positions inside the CMD byte (and inside the registered control vector).
  localparam int B_KEY   = 0;
  localparam int B_BRAKE = 1;
  localparam int B_ACC   = 2;
  localparam int B_R     = 3;
  localparam int B_L     = 4;
  localparam int B_HL    = 5;
  localparam int B_GEAR  = 6;
  localparam int B_RSV   = 7;

  // Control vector {gear, hl, l, r, acc, brake, key}, indexed by the B_* constants.
  typedef logic [6:0] ctrl_t;

  // Stopped, brakes on: used both at reset and when the link watchdog fires.
  localparam ctrl_t FAILSAFE = 7'b000_0010;
  // Headlight is the one output the failsafe leaves alone.
  localparam ctrl_t HL_MASK  = 7'b010_0000;

  typedef enum logic [1:0] {
    HUNT,
    GET_CMD,
    GET_CHK,
    APPLY
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Resolve contradictory requests before they reach the drive controller.
  function automatic ctrl_t sanitise(input logic [7:0] cmd);
    ctrl_t c;
    c = cmd[6:0];
    if (c[B_BRAKE] && c[B_ACC]) begin
      c[B_ACC] = 1'b0;
    end
    if (c[B_L] && c[B_R]) begin
      c[B_L] = 1'b0;
      c[B_R] = 1'b0;
    end
    if (!c[B_KEY]) begin
      c[B_ACC]  = 1'b0;
      c[B_L]    = 1'b0;
      c[B_R]    = 1'b0;
      c[B_GEAR] = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/cmd_link_rx_if.sv
// Serial line in, registered control levels and status pulses out.
interface cmd_link_rx_if;
  logic rx;
  logic key;
  logic brake;
  logic acc;
  logic r;
  logic l;
  logic hl;
  logic gear;
  logic link_up;
  logic pkt_ok;
  logic pkt_err;

  // Handset side: drives the line, observes the controller levels.
  modport master (
    output rx,
    input  key, brake, acc, r, l, hl, gear, link_up, pkt_ok, pkt_err
  );

  // Receiver side.
  modport slave (
    input  rx,
    output key, brake, acc, r, l, hl, gear, link_up, pkt_ok, pkt_err
  );
endinterface

// File: rtl/cmd_link_rx_uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling, LSB-first shifter.
module uart_rx_byte
  import cmd_link_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

  logic [1:0]       r_sync;
  logic             r_rx_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_frame_err;

  logic             w_rx;
  rx_state_t        w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [2:0]       w_bit_nx;
  logic [7:0]       w_shift_nx;
  logic             w_valid_nx;
  logic             w_frame_err_nx;

  assign w_rx = r_sync[1];

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_rx};
      r_rx_prev <= w_rx;
    end
  end

  // Bit timing and shifting: next-state and next-datapath values.
  always_comb begin
    // NOTE: every signal gets a default here, so no path can leave one unassigned and infer a latch.
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_bit_nx       = r_bit;
    w_shift_nx     = r_shift;
    w_valid_nx     = 1'b0;
    w_frame_err_nx = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nx = '0;
        if (r_rx_prev && !w_rx) begin
          w_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
          // A high line at mid start bit was a glitch: drop back silently.
          w_state_nx = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rx, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nx = RX_STOP;
          end else begin
            w_bit_nx = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nx       = '0;
          w_state_nx     = RX_IDLE;
          w_valid_nx     = w_rx;
          w_frame_err_nx = !w_rx;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = RX_IDLE;
      end
    endcase
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit       <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_valid     <= w_valid_nx;
      r_frame_err <= w_frame_err_nx;
    end
  end

  assign o_data      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/cmd_link_rx.sv
// Handset command receiver: packet parser, inter-byte gap timer, link watchdog, output registers.
module cmd_link_rx
  import cmd_link_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int GAP_BITS    = 20,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  cmd_link_rx_if.slave bus
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_SAT   = WD_W'(TIMEOUT_CYC);

  logic [7:0]   w_data;
  logic         w_valid;
  logic         w_frame_err;

  parse_state_t r_state;
  parse_state_t w_state_nx;
  logic [7:0]   r_cmd_byte;
  logic [GAP_W-1:0] r_gap;
  logic [WD_W-1:0]  r_wdog;
  ctrl_t        r_ctrl;
  logic         r_link_up;
  logic         r_pkt_ok;
  logic         r_pkt_err;

  logic         w_in_pkt;
  logic         w_gap_exp;
  logic         w_wd_exp;
  logic         w_cmd_ld;
  logic         w_apply;
  logic         w_err;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx_byte (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (bus.rx),
    .o_data      (w_data),
    .o_valid     (w_valid),
    .o_frame_err (w_frame_err)
  );

  assign w_in_pkt  = (r_state == GET_CMD) || (r_state == GET_CHK);
  assign w_gap_exp = w_in_pkt && (r_gap == GAP_LAST);
  // A packet landing in the expiry cycle takes priority over the failsafe.
  assign w_wd_exp  = (r_wdog == WD_LAST) && !w_apply;

  // Parser next state plus the load/apply/error strobes it raises.
  always_comb begin
    w_state_nx = r_state;
    w_cmd_ld   = 1'b0;
    w_apply    = 1'b0;
    w_err      = w_frame_err;
    case (r_state)
      HUNT: begin
        if (w_valid && (w_data == HDR)) begin
          w_state_nx = GET_CMD;
        end
      end
      GET_CMD: begin
        if (w_frame_err || w_gap_exp) begin
          w_err      = 1'b1;
          w_state_nx = HUNT;
        end else if (w_valid) begin
          w_cmd_ld   = 1'b1;
          w_state_nx = GET_CHK;
        end
      end
      GET_CHK: begin
        if (w_frame_err || w_gap_exp) begin
          w_err      = 1'b1;
          w_state_nx = HUNT;
        end else if (w_valid) begin
          if ((w_data == (HDR ^ r_cmd_byte)) && !r_cmd_byte[B_RSV]) begin
            // Outputs load on the edge entering APPLY so they move one cycle after the CHK byte.
            w_apply    = 1'b1;
            w_state_nx = APPLY;
          end else begin
            w_err      = 1'b1;
            w_state_nx = HUNT;
          end
        end
      end
      APPLY: begin
        w_state_nx = HUNT;
      end
      default: begin
        w_state_nx = HUNT;
      end
    endcase
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Gap timer: runs only inside a packet and restarts on every completed byte.
  always_ff @(posedge clk) begin
    if (rst || !w_in_pkt || w_valid) begin
      r_gap <= '0;
    end else if (!w_gap_exp) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // Link watchdog: free-running, cleared by an accepted packet, saturates at the timeout.
  always_ff @(posedge clk) begin
    if (rst || w_apply) begin
      r_wdog <= '0;
    end else if (r_wdog != WD_SAT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Command byte capture, control levels, link status and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_byte <= '0;
      r_ctrl     <= FAILSAFE;
      r_link_up  <= 1'b0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_pkt_ok  <= w_apply;
      r_pkt_err <= w_err;
      if (w_cmd_ld) begin
        r_cmd_byte <= w_data;
      end
      if (w_apply) begin
        r_ctrl    <= sanitise(r_cmd_byte);
        r_link_up <= 1'b1;
      end else if (w_wd_exp) begin
        r_ctrl    <= (FAILSAFE & ~HL_MASK) | (r_ctrl & HL_MASK);
        r_link_up <= 1'b0;
      end
    end
  end

  assign bus.key     = r_ctrl[B_KEY];
  assign bus.brake   = r_ctrl[B_BRAKE];
  assign bus.acc     = r_ctrl[B_ACC];
  assign bus.r       = r_ctrl[B_R];
  assign bus.l       = r_ctrl[B_L];
  assign bus.hl      = r_ctrl[B_HL];
  assign bus.gear    = r_ctrl[B_GEAR];
  assign bus.link_up = r_link_up;
  assign bus.pkt_ok  = r_pkt_ok;
  assign bus.pkt_err = r_pkt_err;

endmodule

// File: tb/tb_cmd_link_rx.sv
// Self-checking bench for cmd_link_rx: packet table plus hand-written corner sequences,
// with a scoreboard of expected pkt_ok/pkt_err events.
module tb_cmd_link_rx;
  import cmd_link_pkg::*;

  localparam int CLK_HZ      = 1600;
  localparam int BAUD        = 100;
  localparam int BIT_CYC     = CLK_HZ / BAUD;
  localparam int GAP_BITS    = 20;
  localparam int TIMEOUT_CYC = 2000;
  localparam logic [6:0] RST_OUTS = 7'b000_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cmd_link_rx_if bus ();

  cmd_link_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .GAP_BITS    (GAP_BITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       is_err;
    logic [6:0] outs;
    logic       link;
  } ev_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] chk;
    logic       is_err;
    logic [6:0] exp;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[9];

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] m_outs = RST_OUTS;
  logic       m_link = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.gear, bus.hl, bus.l, bus.r, bus.acc, bus.brake, bus.key};
  endfunction

  // Scoreboard consumer: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (bus.pkt_ok || bus.pkt_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.pkt_ok, bus.pkt_err}), 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({bus.pkt_ok, bus.pkt_err}), e.is_err ? 32'd1 : 32'd2);
        check("pulse_outs", 32'(outs()), 32'(e.outs));
        check("pulse_link", 32'(bus.link_up), 32'(e.link));
      end
    end
  end

  task automatic expect_ok(input logic [6:0] o);
    m_outs = o;
    m_link = 1'b1;
    sb.push_back('{is_err: 1'b0, outs: o, link: 1'b1});
  endtask

  task automatic expect_err();
    sb.push_back('{is_err: 1'b1, outs: m_outs, link: m_link});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    bus.rx = stop;
    repeat (BIT_CYC) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] chk);
    send_byte(HDR, 1'b1);
    send_byte(cmd, 1'b1);
    send_byte(chk, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_idle(input string name, input logic [6:0] o, input logic link);
    check({name, "_outs"}, 32'(outs()), 32'(o));
    check({name, "_link"}, 32'(bus.link_up), 32'(link));
  endtask

  initial begin
    vecs[0] = '{8'h07, 8'hA2, 1'b0, 7'b000_0011};
    vecs[1] = '{8'h15, 8'hB0, 1'b0, 7'b001_0101};
    vecs[2] = '{8'h15, 8'hB1, 1'b1, 7'b001_0101};
    vecs[3] = '{8'h19, 8'hBC, 1'b0, 7'b000_0001};
    vecs[4] = '{8'h83, 8'h26, 1'b1, 7'b000_0001};
    vecs[5] = '{8'h62, 8'hC7, 1'b0, 7'b010_0010};
    vecs[6] = '{8'h2B, 8'h8E, 1'b0, 7'b010_1011};
    vecs[7] = '{8'h0D, 8'hA8, 1'b0, 7'b000_1101};
    vecs[8] = '{8'h47, 8'hE2, 1'b0, 7'b100_0011};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset", RST_OUTS, 1'b0);
    check("reset_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    check("reset_pkt_err", 32'(bus.pkt_err), 32'd0);

    // Silent line through a full watchdog period: still down, no error pulses.
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    check_idle("silent", RST_OUTS, 1'b0);

    // Non-header bytes while hunting are ignored without error.
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("hunt_noise_drain");

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_err) begin
        sb.push_back('{is_err: 1'b1, outs: vecs[i].exp, link: m_link});
      end else begin
        expect_ok(vecs[i].exp);
      end
      send_pkt(vecs[i].cmd, vecs[i].chk);
      wait_drain("vec_drain");
      check_idle("vec_hold", vecs[i].exp, 1'b1);
    end

    // Watchdog expiry after a key/acc/l packet.
    expect_ok(7'b001_0101);
    send_pkt(8'h15, 8'hB0);
    wait_drain("wd1_drain");
    repeat (1500) @(negedge clk);
    check_idle("wd1_before", 7'b001_0101, 1'b1);
    repeat (600) @(negedge clk);
    m_outs = RST_OUTS;
    m_link = 1'b0;
    check_idle("wd1_failsafe", RST_OUTS, 1'b0);

    // Reception recovers from failsafe; headlight survives the next expiry.
    expect_ok(7'b010_1011);
    send_pkt(8'h2B, 8'h8E);
    wait_drain("wd2_drain");
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    m_outs = 7'b010_0010;
    m_link = 1'b0;
    check_idle("wd2_failsafe_hl", 7'b010_0010, 1'b0);

    // Framing error on the CMD byte, then a packet with l and r both set.
    send_byte(HDR, 1'b1);
    expect_err();
    send_byte(8'h07, 1'b0);
    wait_drain("frame_drain");
    check_idle("frame_hold", 7'b010_0010, 1'b0);
    expect_ok(7'b000_0001);
    send_pkt(8'h19, 8'hBC);
    wait_drain("lr_drain");

    // Header followed by silence: gap timer must reject the packet.
    expect_err();
    send_byte(HDR, 1'b1);
    repeat (21 * BIT_CYC) @(negedge clk);
    wait_drain("gap_drain");
    check_idle("gap_hold", 7'b000_0001, 1'b1);

    // Reset in the middle of a CMD byte, then a clean packet.
    send_byte(HDR, 1'b1);
    bus.rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    rst    = 1'b0;
    m_outs = RST_OUTS;
    m_link = 1'b0;
    @(negedge clk);
    check_idle("midrst", RST_OUTS, 1'b0);
    check("midrst_pkt_err", 32'(bus.pkt_err), 32'd0);
    repeat (2 * BIT_CYC) @(negedge clk);
    expect_ok(7'b000_0011);
    send_pkt(8'h07, 8'hA2);
    wait_drain("post_rst_drain");
    check_idle("post_rst", 7'b000_0011, 1'b1);

    repeat (50) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_link_rx.md
# cmd_link_rx

Serial command receiver for the robot controller. It deserialises 8N1 UART frames from the remote handset and validates a three-byte command packet. It then drives the level-type control inputs (`key`, `brake`, `acc`, `r`, `l`, `hl`, `gear`) that the drive/gear controller consumes in place of board switches. A link watchdog forces a safe stopped state when the handset goes silent.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 9600, serial bit rate. `BIT_CYC = CLK_HZ/BAUD` (5208), integer-truncated.
- `GAP_BITS`, 20, maximum idle bit-times between bytes of one packet.
- `TIMEOUT_CYC`, 25_000_000, maximum cycles between valid packets before failsafe (0.5 s).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `rx`  in  1  asynchronous UART line, idle high.
- `key, brake, acc, r, l, hl, gear`  out  1 each  registered command levels to the controller.
- `link_up`  out  1  high while valid packets arrive within `TIMEOUT_CYC`.
- `pkt_ok`  out  1  one-cycle pulse per accepted packet.
- `pkt_err`  out  1  one-cycle pulse per rejected byte or packet (framing, checksum, gap).

## Operation
- `rx` passes through a 2-flop synchroniser before use. It adds 2 cycles of latency.
- Byte receiver:
  - A falling edge in idle starts the bit counter. The start bit is re-sampled at `BIT_CYC/2`, and if it is high the receiver returns to idle silently.
  - The 8 data bits are sampled LSB first at mid-bit, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and `pkt_err` pulses.
- Packet: `HDR`=0xA5, `CMD`, `CHK`=`HDR ^ CMD`.
- `CMD` bit map: b0 key, b1 brake, b2 acc, b3 r, b4 l, b5 hl, b6 gear, b7 reserved (must be 0).
- Parser FSM:
  - HUNT: a byte equal to 0xA5 moves to GET_CMD. Any other byte stays in HUNT with no error.
  - GET_CMD: stores the byte and moves to GET_CHK.
  - GET_CHK: on checksum match with b7=0, moves to APPLY. Otherwise `pkt_err` pulses and the FSM returns to HUNT.
  - APPLY: updates the outputs, pulses `pkt_ok`, clears the watchdog and sets `link_up`. Then returns to HUNT.
- Gap timer: in GET_CMD or GET_CHK, if `GAP_BITS*BIT_CYC` cycles pass without a completed byte, `pkt_err` pulses and the FSM returns to HUNT.
- A framing error in GET_CMD or GET_CHK pulses `pkt_err` and returns the FSM to HUNT.
- Conflict sanitising in APPLY:
  - `brake` and `acc` both set: `acc` is forced to 0.
  - `l` and `r` both set: both are forced to 0.
  - `key`=0: `acc`, `l`, `r` and `gear` are forced to 0.
- Watchdog: counts every cycle and is cleared only in APPLY. On reaching `TIMEOUT_CYC`:
  - `link_up` goes to 0.
  - Failsafe outputs are applied: `key`=0, `brake`=1, `acc`=`r`=`l`=`gear`=0.
  - `hl` holds its last value.
  - The counter saturates; it does not wrap.
- A failsafe already in force does not block reception. The next valid packet restores normal operation.

## Timing
- Reset values:
  - `key`=`acc`=`r`=`l`=`hl`=`gear`=0, `brake`=1.
  - `link_up`=0, `pkt_ok`=`pkt_err`=0.
  - FSM in HUNT; byte receiver idle; counters 0.
- Reset mid-byte or mid-packet abandons all partial data. The first falling edge after `rst` deasserts starts a fresh byte.
- Output latency: command outputs, `pkt_ok` and `link_up` change 1 cycle after the CHK stop-bit sample. All change in the same cycle.
- `pkt_err` is asserted 1 cycle after the offending stop-bit sample, or after gap expiry.
- Simultaneous events, watchdog expiry in the same cycle as APPLY: APPLY wins, so outputs take the packet values and `link_up` stays 1.
- Outputs are stable between packets. There is no per-cycle decoding glitch because every output is a flop.

## Structure
- Package `cmd_link_pkg`:
  - `HDR` = 8'hA5.
  - `CMD` bit-index constants: `B_KEY`…`B_GEAR`, `B_RSV`.
  - Parser state enum: HUNT, GET_CMD, GET_CHK, APPLY.
  - Failsafe output vector constant.
- Sub-module `uart_rx_byte` (parameters `CLK_HZ`, `BAUD`):
  - Contains the synchroniser, bit timing and shifter.
  - Outputs: `data[7:0]`, `valid` pulse, `frame_err` pulse.
- The top level contains the parser FSM, gap timer, watchdog and output registers.

## Test plan
- Reset release, no traffic → outputs at reset values. After `TIMEOUT_CYC` cycles, `link_up` stays 0 and there is no `pkt_err`.
- Send A5, 07, A2 → `key`=`brake`=`acc`=1 at the packet, sanitised to `acc`=0. Result: `key`=1, `brake`=1, `pkt_ok` once, `link_up`=1.
- Send A5, 15, B0 (key, acc, l) → `key`=`acc`=`l`=1, all other outputs 0. Then idle for `TIMEOUT_CYC` cycles → failsafe with `brake`=1, `key`=0 and `link_up`=0.
- Send A5, 15, B1 (bad checksum) → `pkt_err` pulses once and the outputs are unchanged.
- Send A5, then a stop bit driven low on the next byte → `pkt_err` pulses and the FSM returns to HUNT. Then A5, 19, BC → `key`, `r`, `l` set at the packet; with `l` and `r` both set, both are cleared, giving `key`=1 only.
- Send A5, then hold `rx` high for 21 bit-times → `pkt_err` from the gap timer. Then assert `rst` midway through the next packet's CMD byte → everything returns to reset values, and a following good packet is accepted.
